// File: rtl/sample_hex_tx.sv
// UART transmitter that renders each accepted sample as uppercase ASCII hex plus CR LF.
// Frames are 8N1 at a fixed CLOCKS_PER_BAUD divisor; input is accepted only while idle.
module sample_hex_tx #(
    parameter int unsigned CLOCKS_PER_BAUD = 868,
    parameter int unsigned SAMPLE_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    busy,
    output logic                    txd
);
    localparam int unsigned Nibbles = SAMPLE_WIDTH / 4;
    localparam int unsigned CntW    = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLOCKS_PER_BAUD - 1);
    localparam logic [3:0]      CrChar   = 4'(Nibbles);
    localparam logic [3:0]      LfChar   = 4'(Nibbles + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         baud_q, baud_d;
    logic [2:0]              bit_q, bit_d;
    logic [3:0]              char_q, char_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic [3:0]              nibble;
    logic [7:0]              cur_char;
    logic                    baud_tick;

    assign baud_tick = (baud_q == BaudLast);

    // Character index 0 is the most-significant nibble; the last two indices are CR and LF.
    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < Nibbles; i++) begin
            if (char_q == 4'(Nibbles - 1 - i)) begin
                nibble = sample_q[4*i +: 4];
            end
        end
        if (char_q == CrChar) begin
            cur_char = 8'h0D;
        end else if (char_q == LfChar) begin
            cur_char = 8'h0A;
        end else if (nibble < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nibble};
        end else begin
            cur_char = 8'h37 + {4'h0, nibble};
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        char_d   = char_q;
        sample_d = sample_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        txd      = 1'b1;

        // Counter wraps on every bit boundary so character timing never drifts.
        if (state_q != StIdle) begin
            baud_d = baud_tick ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    sample_d = in_data;
                    char_d   = '0;
                    bit_d    = '0;
                    baud_d   = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                txd = 1'b0;
                if (baud_tick) begin
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                txd = cur_char[bit_q];
                if (baud_tick) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (baud_tick) begin
                    if (char_q < LfChar) begin
                        char_d  = char_q + 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            char_q   <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            char_q   <= char_d;
            sample_q <= sample_d;
        end
    end

endmodule

// File: tb/tb_sample_hex_tx.sv
// Bench for sample_hex_tx: per-instance UART monitors decode txd and compare against a
// scoreboard of expected characters pushed when each sample is offered.
module tb_sample_hex_tx;
    localparam int CpbN = 4;
    localparam int CpbW = 7;
    localparam int CpbB = 868;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  data_n, data_b;
    logic [31:0] data_w;
    logic        valid_n, valid_w, valid_b;
    logic        ready_n, ready_w, ready_b;
    logic        busy_n, busy_w, busy_b;
    logic        txd_n, txd_w, txd_b;

    sample_hex_tx #(.CLOCKS_PER_BAUD(CpbN), .SAMPLE_WIDTH(8)) u_dut_n (
        .clk(clk), .rst(rst), .in_data(data_n), .in_valid(valid_n),
        .in_ready(ready_n), .busy(busy_n), .txd(txd_n)
    );
    sample_hex_tx #(.CLOCKS_PER_BAUD(CpbW), .SAMPLE_WIDTH(32)) u_dut_w (
        .clk(clk), .rst(rst), .in_data(data_w), .in_valid(valid_w),
        .in_ready(ready_w), .busy(busy_w), .txd(txd_w)
    );
    sample_hex_tx #(.CLOCKS_PER_BAUD(CpbB), .SAMPLE_WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(data_b), .in_valid(valid_b),
        .in_ready(ready_b), .busy(busy_b), .txd(txd_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_n[$];
    logic [7:0] exp_w[$];
    logic [7:0] exp_b[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    endtask

    function automatic logic get_txd(input int sel);
        case (sel)
            0:       return txd_n;
            1:       return txd_w;
            default: return txd_b;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return ready_n;
            1:       return ready_w;
            default: return ready_b;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy_n;
            1:       return busy_w;
            default: return busy_b;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] d);
        case (sel)
            0:       begin valid_n = v; data_n = d[7:0]; end
            1:       begin valid_w = v; data_w = d;      end
            default: begin valid_b = v; data_b = d[7:0]; end
        endcase
    endtask

    task automatic push_char(input int sel, input logic [7:0] c);
        case (sel)
            0:       exp_n.push_back(c);
            1:       exp_w.push_back(c);
            default: exp_b.push_back(c);
        endcase
    endtask

    task automatic push_frame(input int sel, input logic [31:0] s, input int nib);
        string hx = "0123456789ABCDEF";
        int    idx;
        for (int i = nib - 1; i >= 0; i--) begin
            idx = int'((s >> (4 * i)) & 32'hF);
            push_char(sel, hx[idx]);
        end
        push_char(sel, 8'h0D);
        push_char(sel, 8'h0A);
    endtask

    task automatic pop_check(input int sel, input logic [7:0] got);
        logic [7:0] want;
        bit         have;
        want = 8'h00;
        case (sel)
            0:       begin have = exp_n.size() > 0; if (have) want = exp_n.pop_front(); end
            1:       begin have = exp_w.size() > 0; if (have) want = exp_w.pop_front(); end
            default: begin have = exp_b.size() > 0; if (have) want = exp_b.pop_front(); end
        endcase
        check($sformatf("rx_expected%0d", sel), have, 1);
        if (have) check($sformatf("rx_char%0d", sel), got, want);
    endtask

    // Called on the first sampled cycle of a start bit; samples every cycle of all ten bits.
    task automatic rx_char(input int sel, input int cpb);
        logic [9:0] bits;
        logic       v, first;
        bit         stable;
        stable = 1'b1;
        bits   = '0;
        first  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < cpb; c++) begin
                if (k != 0 || c != 0) begin
                    @(posedge clk);
                    #1;
                end
                if (rst) return;
                v = get_txd(sel);
                if (c == 0) first = v;
                else if (v !== first) stable = 1'b0;
            end
            bits[k] = first;
        end
        check($sformatf("bit_width%0d", sel), stable, 1);
        check($sformatf("framing%0d", sel), {bits[9], bits[0]}, 2'b10);
        pop_check(sel, bits[8:1]);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst && get_txd(0) === 1'b0) rx_char(0, CpbN);
    end
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst && get_txd(1) === 1'b0) rx_char(1, CpbW);
    end
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst && get_txd(2) === 1'b0) rx_char(2, CpbB);
    end

    task automatic wait_hs(input int sel, input int budget, output int waited);
        bit rdy;
        waited = 0;
        do begin
            rdy = get_ready(sel);
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < budget);
        check($sformatf("handshake%0d", sel), rdy, 1);
    endtask

    task automatic send(input int sel, input logic [31:0] d, input int nib);
        int w;
        push_frame(sel, d, nib);
        drive(sel, 1'b1, d);
        wait_hs(sel, 50, w);
        drive(sel, 1'b0, 32'h0);
    endtask

    task automatic wait_idle(input int sel, input int budget, output int cnt);
        cnt = 0;
        while (get_busy(sel) && cnt < budget) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int w, cnt;
        logic [31:0] r;
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        drive(2, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd_n, 1);
        check("rst_busy", busy_n, 0);
        check("rst_ready", ready_n, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_txd_w", txd_w, 1);
        check("idle_ready_b", ready_b, 1);

        // Single sample 0x3A
        send(0, 32'h3A, 2);
        check("start_latency", txd_n, 0);
        check("busy_on", busy_n, 1);
        check("ready_off", ready_n, 0);
        wait_idle(0, 1000, cnt);
        check("frame_len", cnt, 160);
        check("ready_back", ready_n, 1);

        // Back-to-back with in_valid held high
        push_frame(0, 32'h00, 2);
        push_frame(0, 32'hFF, 2);
        drive(0, 1'b1, 32'h00);
        wait_hs(0, 50, w);
        drive(0, 1'b1, 32'hFF);
        wait_hs(0, 400, w);
        drive(0, 1'b0, 32'h0);
        check("b2b_spacing", w, 161);
        check("ready_pulse", ready_n, 0);
        wait_idle(0, 1000, cnt);
        check("b2b_len2", cnt, 160);

        // Input activity while busy must not disturb or extend the frame
        send(0, 32'hC5, 2);
        for (int i = 0; i < 100; i++) begin
            drive(0, i[0], $urandom);
            @(posedge clk);
            #1;
            if (i == 50) check("ready_busy", ready_n, 0);
        end
        drive(0, 1'b0, 32'h0);
        wait_idle(0, 1000, cnt);
        repeat (30) @(posedge clk);
        #1;
        check("no_extra", busy_n, 0);

        // Reset during the data bits of the CR character
        send(0, 32'h96, 2);
        repeat (90) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_txd", txd_n, 1);
        check("rst_mid_ready", ready_n, 1);
        check("rst_mid_busy", busy_n, 0);
        exp_n.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(0, 32'h7F, 2);
        wait_idle(0, 1000, cnt);
        check("post_rst_len", cnt, 160);

        // 32-bit samples
        send(1, 32'h0123ABCD, 8);
        wait_idle(1, 2000, cnt);
        check("wide_len", cnt, 700);
        r = $urandom;
        send(1, r, 8);
        wait_idle(1, 2000, cnt);

        // Full-rate divisor
        send(2, 32'h55, 2);
        wait_idle(2, 40000, cnt);
        check("baud_len", cnt, 34720);

        repeat (20) @(posedge clk);
        #1;
        check("drain_n", exp_n.size(), 0);
        check("drain_w", exp_w.size(), 0);
        check("drain_b", exp_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
